// File: rtl/div20_10_seq.sv
// div20_10_seq: sequential radix-2 restoring divider.
// Divides a WN-bit dividend by a WD-bit divisor, producing one quotient bit
// per clock. A zero divisor finishes in one cycle with dz set.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// CALC  | one quotient bit per cycle, busy=1
// DONE  | one-cycle done pulse, ready=1, back-to-back start allowed
module div20_10_seq #(
  parameter int WN = 20,
  parameter int WD = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WN-1:0] z,
  input  logic [WD-1:0] y,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] q,
  output logic [WD-1:0] r,
  output logic          dz
);

  localparam int CW = $clog2(WN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [WD-1:0] partial;   // running remainder; always < y, so WD bits suffice
  logic [WN-1:0] qsr;       // dividend bits shift out the top, quotient bits in the bottom
  logic [WD-1:0] y_reg;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          last;
  logic [WD:0]   trial;     // one bit wider than the divisor so the compare cannot overflow
  logic          take;
  logic [WD-1:0] part_nxt;
  logic [WN-1:0] qsr_nxt;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CNT_ONE);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial    = {partial, qsr[WN-1]};
    take     = (trial >= {1'b0, y_reg});
    // The difference is < y whenever it is taken, so the low WD bits are exact.
    part_nxt = take ? (trial[WD-1:0] - y_reg) : trial[WD-1:0];
    qsr_nxt  = {qsr[WN-2:0], take};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (y == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) state_nxt = (y == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial <= '0;
      qsr     <= '0;
      y_reg   <= '0;
      cnt     <= '0;
      q       <= '0;
      r       <= '0;
      dz      <= 1'b0;
    end else if (accept) begin
      partial <= '0;
      qsr     <= z;
      y_reg   <= y;
      cnt     <= CNT_LOAD;
      if (y == '0) begin
        q  <= '1;
        r  <= z[WD-1:0];
        dz <= 1'b1;
      end
    end else if (state == CALC) begin
      partial <= part_nxt;
      qsr     <= qsr_nxt;
      cnt     <= cnt - CNT_ONE;
      // Results update only on the final step so they hold steady during CALC.
      if (last) begin
        q  <= qsr_nxt;
        r  <= part_nxt;
        dz <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div20_10_seq.sv
// Directed and random checks for div20_10_seq.
module tb_div20_10_seq;

  localparam int WN = 20;
  localparam int WD = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WN-1:0] z = '0;
  logic [WD-1:0] y = '0;
  logic          ready, busy, done, dz;
  logic [WN-1:0] q;
  logic [WD-1:0] r;

  int n_asserts = 0;
  int n_fail    = 0;

  div20_10_seq #(.WN(WN), .WD(WD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .z(z), .y(y),
    .ready(ready), .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts an operation at the next negedge and waits (bounded) for done.
  // Returns at the negedge of the done cycle.
  task automatic run_op(input logic [WN-1:0] zv, input logic [WD-1:0] yv,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    z = zv; y = yv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int lat, bc, done_seen;
    logic [WN-1:0] rz;
    logic [WD-1:0] ry;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy",  {63'd0, busy},  64'd0);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_q",     64'(q),         64'd0);
    check("rst_r",     64'(r),         64'd0);
    check("rst_dz",    {63'd0, dz},    64'd0);

    // 1023000 / 1023 with latency
    run_op(20'd1023000, 10'd1023, lat, bc);
    check("a_lat",  64'(lat), 64'd21);
    check("a_busy", 64'(bc),  64'd20);
    check("a_q",    64'(q),   64'd1000);
    check("a_r",    64'(r),   64'd0);
    check("a_dz",   {63'd0, dz}, 64'd0);
    @(negedge clk);
    check("a_done_pulse", {63'd0, done}, 64'd0);
    check("a_q_hold",     64'(q),        64'd1000);

    run_op(20'd1048575, 10'd1, lat, bc);
    check("b_q", 64'(q), 64'd1048575);
    check("b_r", 64'(r), 64'd0);
    run_op(20'd5, 10'd10, lat, bc);
    check("c_q", 64'(q), 64'd0);
    check("c_r", 64'(r), 64'd5);
    run_op(20'd1000, 10'd7, lat, bc);
    check("d_q", 64'(q), 64'd142);
    check("d_r", 64'(r), 64'd6);

    // Divide by zero
    run_op(20'd12345, 10'd0, lat, bc);
    check("z_lat", 64'(lat), 64'd1);
    check("z_dz",  {63'd0, dz}, 64'd1);
    check("z_q",   64'(q), 64'hFFFFF);
    check("z_r",   64'(r), 64'd57);
    run_op(20'd100, 10'd9, lat, bc);
    check("z_clear_dz", {63'd0, dz}, 64'd0);
    check("z_next_q",   64'(q), 64'd11);
    check("z_next_r",   64'(r), 64'd1);

    // start re-pulsed mid-CALC is ignored
    @(negedge clk);
    z = 20'd1000; y = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    z = 20'd999; y = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("m_busy", {63'd0, busy}, 64'd1);
    check("m_q_hold", 64'(q), 64'd11);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    check("m_done_seen", {63'd0, done}, 64'd1);
    check("m_lat", 64'(lat), 64'd15);
    check("m_q", 64'(q), 64'd142);
    check("m_r", 64'(r), 64'd6);

    // Back-to-back: start held high through done
    @(negedge clk);
    z = 20'd50000; y = 10'd300; start = 1'b1;
    @(negedge clk);
    z = 20'd77777; y = 10'd777;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    check("bb1_done_seen", {63'd0, done}, 64'd1);
    check("bb1_lat", 64'(lat), 64'd21);
    check("bb1_q", 64'(q), 64'd166);
    check("bb1_r", 64'(r), 64'd200);
    @(negedge clk);
    start = 1'b0;
    check("bb2_no_idle", {63'd0, busy}, 64'd1);
    check("bb2_q_hold",  64'(q), 64'd166);
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    check("bb2_done_seen", {63'd0, done}, 64'd1);
    check("bb2_lat", 64'(lat), 64'd21);
    check("bb2_q", 64'(q), 64'd100);
    check("bb2_r", 64'(r), 64'd77);

    // Asynchronous reset mid-operation
    @(negedge clk);
    z = 20'd654321; y = 10'd123; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("ar_busy_before", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",  {63'd0, busy},  64'd0);
    check("ar_ready", {63'd0, ready}, 64'd1);
    check("ar_q",     64'(q),         64'd0);
    check("ar_r",     64'(r),         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("ar_no_done", 64'(done_seen), 64'd0);

    // Random operations: exact quotient/remainder and the division invariant
    for (int i = 0; i < 1000; i++) begin
      rz = WN'($urandom_range(0, 1048575));
      ry = WD'($urandom_range(1, 1023));
      run_op(rz, ry, lat, bc);
      check("rnd_q",   64'(q), 64'(rz) / 64'(ry));
      check("rnd_r",   64'(r), 64'(rz) % 64'(ry));
      check("rnd_inv", 64'(q) * 64'(ry) + 64'(r), 64'(rz));
      check("rnd_rlt", {63'd0, (r < ry)}, 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
